// File: rtl/countdown_pkg.sv
// rtl/countdown_pkg.sv - shared types and constants for the countdown timer
package countdown_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable down-counter with single-cycle expiry pulse
//
// Ports:
//   clk    - clock, all state updates on rising edge
//   rst    - synchronous active-high reset, overrides every other input
//   en     - count enable, one decrement per enabled cycle while running
//   start  - load v and begin counting (v == 0 gives an immediate done pulse)
//   abort  - stop counting at once, clear count, no done pulse
//   v      - preset value, sampled when start is accepted
//   count  - remaining count
//   busy   - high while running (registered state decode)
//   done   - one-cycle pulse on expiry
//
// Build option COUNTDOWN_AUTO_RELOAD_EN: on expiry reload the last preset
// and keep running, producing a periodic done pulse.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] v,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] reload_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             done_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            reload <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            reload <= reload_nxt;
            done   <= done_nxt;
        end
    end

    // abort > start > en; done is a pulse, so it is cleared unless set here.
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        reload_nxt = reload;
        done_nxt   = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
            count_nxt = '0;
        end else if (start) begin
            if (v == '0) begin
                // zero-length timer: expire immediately, never enter RUN
                state_nxt = IDLE;
                count_nxt = '0;
                done_nxt  = 1'b1;
            end else begin
                state_nxt  = RUN;
                count_nxt  = v;
                reload_nxt = v;
            end
        end else if (state == RUN && en) begin
            if (count > ONE) begin
                count_nxt = count - ONE;
            end else begin
                // final step: done coincides with the cycle the count expires,
                // and the count never steps past zero
                done_nxt = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                count_nxt = reload;
`else
                count_nxt = '0;
                state_nxt = IDLE;
`endif
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - self-checking bench for countdown_timer
module tb_countdown_timer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] v = '0;
    logic [W-1:0] count;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    // reference model state: plain integers, one timer run at a time
    int m_count = 0;
    int m_reload = 0;
    bit m_run = 0;
    bit m_done = 0;

    countdown_timer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .start (start),
        .abort (abort),
        .v     (v),
        .count (count),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input bit s, input bit a, input int val);
        m_done = 0;
        if (r) begin
            m_count = 0; m_run = 0; m_reload = 0;
        end else if (a) begin
            m_count = 0; m_run = 0;
        end else if (s) begin
            if (val == 0) begin
                m_count = 0; m_run = 0; m_done = 1;
            end else begin
                m_count = val; m_reload = val; m_run = 1;
            end
        end else if (m_run && e) begin
            m_count = m_count - 1;
            if (m_count == 0) begin
                m_done = 1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                m_count = m_reload;
`else
                m_run = 0;
`endif
            end
        end
    endtask

    // drive one cycle, advance the model, then compare just after the edge
    task automatic tick(input bit r, input bit e, input bit s, input bit a, input int val);
        rst = r; en = e; start = s; abort = a; v = W'(val);
        @(posedge clk);
        model_step(r, e, s, a, val);
        #1;
        chk("model_count", 32'(count), 32'(m_count));
        chk("model_busy", 32'(busy), 32'(m_run));
        chk("model_done", 32'(done), 32'(m_done));
    endtask

    initial begin
        int ndone;
        int gate_en [6]  = '{1, 0, 0, 1, 0, 1};
        int gate_cnt [6] = '{2, 2, 2, 1, 1, 0};

        #1;
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        chk("reset_count", 32'(count), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);

`ifndef COUNTDOWN_AUTO_RELOAD_EN
        // basic expiry
        tick(0, 1, 1, 0, 5);
        chk("basic_busy_after_start", 32'(busy), 1);
        chk("basic_count_load", 32'(count), 5);
        for (int i = 4; i >= 0; i--) begin
            tick(0, 1, 0, 0, 0);
            chk("basic_count", 32'(count), 32'(i));
            chk("basic_done", 32'(done), (i == 0) ? 1 : 0);
            chk("basic_busy", 32'(busy), (i == 0) ? 0 : 1);
        end
        tick(0, 1, 0, 0, 0);
        chk("basic_done_single", 32'(done), 0);

        // enable gating
        tick(0, 0, 1, 0, 3);
        chk("gate_load", 32'(count), 3);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            tick(0, gate_en[i][0], 0, 0, 0);
            chk("gate_count", 32'(count), 32'(gate_cnt[i]));
            ndone += int'(done);
        end
        chk("gate_done_once", 32'(ndone), 1);
        chk("gate_done_last", 32'(done), 1);

        // abort at count 6
        ndone = 0;
        tick(0, 1, 1, 0, 10);
        for (int i = 0; i < 4; i++) begin
            tick(0, 1, 0, 0, 0);
            ndone += int'(done);
        end
        chk("abort_pre_count", 32'(count), 6);
        tick(0, 1, 0, 1, 0);
        ndone += int'(done);
        chk("abort_count", 32'(count), 0);
        chk("abort_busy", 32'(busy), 0);
        tick(0, 1, 0, 0, 0);
        ndone += int'(done);
        chk("abort_no_done", 32'(ndone), 0);

        // restart, then zero preset from IDLE
        tick(0, 1, 1, 0, 7);
        for (int i = 0; i < 3; i++) tick(0, 1, 0, 0, 0);
        chk("restart_pre", 32'(count), 4);
        tick(0, 1, 1, 0, 7);
        chk("restart_count", 32'(count), 7);
        chk("restart_busy", 32'(busy), 1);
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 1, 0, 0);
        chk("zero_done", 32'(done), 1);
        chk("zero_busy", 32'(busy), 0);
        chk("zero_count", 32'(count), 0);
        tick(0, 0, 0, 0, 0);
        chk("zero_done_single", 32'(done), 0);

        // reset mid-run, width bound
        tick(0, 1, 1, 0, 255);
        for (int i = 0; i < 127; i++) tick(0, 1, 0, 0, 0);
        chk("wide_pre", 32'(count), 32'h80);
        tick(1, 1, 0, 0, 0);
        chk("midrst_count", 32'(count), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        tick(0, 1, 1, 0, 1);
        tick(0, 1, 0, 0, 0);
        chk("one_count", 32'(count), 0);
        chk("one_done", 32'(done), 1);
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 0, 0, 0);
            chk("no_wrap", 32'(count), 0);
        end
`else
        // periodic pulses every 3 enabled cycles
        tick(0, 1, 1, 0, 3);
        chk("auto_load", 32'(count), 3);
        for (int i = 1; i <= 10; i++) begin
            tick(0, 1, 0, 0, 0);
            chk("auto_done", 32'(done), (i % 3 == 0) ? 1 : 0);
            chk("auto_busy", 32'(busy), 1);
            chk("auto_count", 32'(count), 32'(3 - (i % 3)));
        end
        tick(0, 1, 0, 1, 0);
        chk("auto_abort_busy", 32'(busy), 0);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            bit r, e, s, a;
            int val;
            r   = ($urandom_range(0, 59) == 0);
            a   = ($urandom_range(0, 24) == 0);
            s   = ($urandom_range(0, 11) == 0);
            e   = ($urandom_range(0, 2) != 0);
            val = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                              : int'($urandom_range(0, 9));
            tick(r, e, s, a, val);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counter: the complement of the existing load/accumulate up-counter.
- Takes a preset value, decrements once per enabled cycle, and emits a single-cycle done pulse on reaching zero.
- Provides timed delays and periodic events to the lab top level, driven from a prescaler tick or tied-high enable.
- Count value is exposed for display.

Parameters:
- WIDTH, 8, bit width of preset value and count.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- en  input  1  count enable; decrement permitted only on cycles where en=1
- start  input  1  load v and begin counting
- abort  input  1  stop counting immediately, no done pulse
- v  input  WIDTH  preset value, sampled when start accepted
- count  output  WIDTH  current remaining count
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse on expiry

Behaviour:
- Reset: rst is synchronous and active-high; it has priority over every other input.
  - On reset: count=0, busy=0, done=0, reload register=0, state=IDLE.
  - Reset asserted mid-count discards the run with no done pulse.
- States: IDLE, RUN. busy is 1 exactly when state=RUN (registered, no combinational path from inputs).
- done defaults to 0 every cycle unless set as below; it is never high for two consecutive cycles from a single expiry.
- Priority within a cycle (rst excluded): abort > start > en.
- IDLE:
  - start=1, v!=0: count<=v, reload<=v, state<=RUN. busy is high the next cycle.
  - start=1, v==0: count<=0, done<=1, state stays IDLE (zero-length timer).
  - en alone: no effect; count holds.
- RUN:
  - abort=1: count<=0, state<=IDLE, done stays 0.
  - start=1: restart. count<=v, reload<=v; v==0 behaves as in IDLE (done pulse, go IDLE).
  - en=1, count>1: count<=count-1.
  - en=1, count==1: count<=0, done<=1, state<=IDLE. done is visible in the same cycle count first reads 0.
  - en=0: all state holds.
- Latency:
  - start to busy: 1 cycle.
  - Preset N with en tied high: done is high in cycle N after the start edge.
- Arithmetic: count never decrements below 0 and never wraps to all-ones. Max preset is 2^WIDTH-1.
- abort in IDLE: count<=0, no other effect.

Optional Feature:
- Macro: COUNTDOWN_AUTO_RELOAD_EN.
- Defined: on expiry (RUN, en=1, count==1) count<=reload, done<=1, state stays RUN, busy stays 1. This gives a periodic done pulse every reload enabled cycles until abort, rst, or start.
- Not defined: expiry returns to IDLE as above.
- Unaffected by the macro: the v==0 start path (always returns IDLE) and the abort/rst behaviour.

Decomposition:
- Package countdown_pkg holds:
  - typedef enum logic [0:0] state_t {IDLE, RUN};
  - localparam DEFAULT_WIDTH = 8.
- Single module; no sub-module. The datapath is one register plus a decrementer, which does not justify a split.

Test Plan:
- Basic expiry: rst 2 cycles; start=1, v=5, en=1 -> busy=1 next cycle; count 5,4,3,2,1,0; done=1 only in the cycle count=0; busy=0 that cycle.
- Enable gating: v=3, en toggling 1,0,0,1,0,1 -> count 3,2,2,2,1,1,0; done asserted once, on the final step.
- Abort: v=10, en=1, abort at count=6 -> next cycle count=0, busy=0, done never asserted.
- Restart and zero preset: in RUN at count=4, start with v=7 -> count=7. Then in IDLE, start with v=0 -> done=1 next cycle, busy stays 0.
- Reset mid-run and width bound: v=8'hFF, en=1, rst at count=0x80 -> count=0, busy=0, done=0. Rerun v=1 -> count 0 next step, never 0xFF after 0.
- Auto-reload (macro defined): v=3, en=1 for 10 cycles -> done pulses at enabled steps 3, 6, 9; busy stays 1; count sequence 3,2,1,3,2,1,...
